// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: load-use bubbles, branch flushes,
// data-memory wait stalls with timeout, and halt handling.
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] id_rs,
  input  logic [2:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [2:0] ex_rd,
  input  logic       ex_regWrite,
  input  logic       ex_memRead,
  input  logic       branch_taken,
  input  logic       dmem_req,
  input  logic       dmem_done,
  input  logic       wb_halt,
  output logic       front_stall,
  output logic       idex_bubble,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       pipe_stall,
  output logic       halted,
  output logic       err,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALTED   = 2'b10,
    BAD      = 2'b11
  } state_t;

  state_t     cur, nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       halted_q, halted_nxt;
  logic       err_q, err_nxt;
  logic       stall_raw;
  logic       mem_wait;
  logic       lu;

  assign mem_wait = dmem_req & ~dmem_done;

  assign lu = ex_memRead & ex_regWrite &
              ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur      <= RUN;
      cnt      <= 4'd0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cur      <= nxt;
      cnt      <= cnt_nxt;
      halted_q <= halted_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    nxt        = cur;
    cnt_nxt    = cnt;
    halted_nxt = halted_q;
    err_nxt    = err_q;
    stall_raw  = 1'b0;
    case (cur)
      RUN: begin
        stall_raw = mem_wait;
        if (mem_wait) begin
          nxt     = MEM_WAIT;
          cnt_nxt = 4'd0;
        end else if (wb_halt) begin
          nxt        = HALTED;
          halted_nxt = 1'b1;
        end
      end
      MEM_WAIT: begin
        stall_raw = ~dmem_done;
        if (dmem_done) begin
          // Release cycle is unstalled, so a halt in WB is honoured here too.
          if (wb_halt) begin
            nxt        = HALTED;
            halted_nxt = 1'b1;
          end else begin
            nxt = RUN;
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
          if (cnt == 4'd14) begin
            nxt     = HALTED;
            err_nxt = 1'b1;
          end
        end
      end
      default: stall_raw = 1'b1;
    endcase
  end

  assign pipe_stall  = rst & stall_raw;
  assign ifid_flush  = rst & ~stall_raw & branch_taken;
  assign idex_flush  = rst & ~stall_raw & branch_taken;
  assign front_stall = rst & ~stall_raw & ~branch_taken & lu;
  assign idex_bubble = rst & ~stall_raw & ~branch_taken & lu;
  assign halted      = halted_q;
  assign err         = err_q | (cur == BAD);
  assign state       = cur;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset; synchronous, active-low (rst=0 resets on the next rising clk edge).
REQ-003 SHALL have ports id_rs, id_rt  in  3 each  source register numbers of the instruction in ID.
REQ-004 SHALL have ports id_rs_used, id_rt_used  in  1 each  ID instruction actually reads rs/rt.
REQ-005 SHALL have ports ex_rd  in  3, ex_regWrite  in  1, ex_memRead  in  1  destination/control of the instruction in EX.
REQ-006 SHALL have port branch_taken  in  1  EX-stage redirect (taken branch, jump or jump-register).
REQ-007 SHALL have ports dmem_req  in  1 (MEM stage memRead|memWrite), dmem_done  in  1 (data memory ack, valid same cycle as req or later).
REQ-008 SHALL have port wb_halt  in  1  halt instruction in WB.
REQ-009 SHALL have port front_stall  out  1  hold PC and IF/ID.
REQ-010 SHALL have port idex_bubble  out  1  load ID/EX with a NOP.
REQ-011 SHALL have ports ifid_flush, idex_flush  out  1 each  squash IF/ID and ID/EX contents.
REQ-012 SHALL have port pipe_stall  out  1  freeze every pipeline register and PC.
REQ-013 SHALL have ports halted  out  1, err  out  1, state  out  2  (RUN=00, MEM_WAIT=01, HALTED=10).

Function
REQ-014 SHALL implement FSM states RUN, MEM_WAIT, HALTED; 11 unreachable, decoded as HALTED with err=1.
REQ-015 SHALL hold a 4-bit wait counter, cleared on entry to MEM_WAIT, +1 per MEM_WAIT cycle without dmem_done.
REQ-016 SHALL compute mem_wait = dmem_req & ~dmem_done (combinational).
REQ-017 SHALL drive pipe_stall = 1 in RUN when mem_wait=1; in MEM_WAIT while dmem_done=0; always in HALTED; else 0.
REQ-018 SHALL transition RUN->MEM_WAIT when mem_wait=1; dmem_req & dmem_done in same cycle -> stay RUN, no stall.
REQ-019 SHALL transition MEM_WAIT->RUN in the cycle dmem_done=1, with pipe_stall=0 in that cycle (zero-cycle release).
REQ-020 SHALL transition MEM_WAIT->HALTED and set err=1 when counter reaches 15 with dmem_done=0 (16th wait cycle overall).
REQ-021 SHALL detect load-use: lu = ex_memRead & ex_regWrite & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)); register 0 not special.
REQ-022 SHALL assert front_stall=1 and idex_bubble=1 for one cycle when lu=1, branch_taken=0, pipe_stall=0; no state change.
REQ-023 SHALL assert ifid_flush=1 and idex_flush=1 when branch_taken=1 and pipe_stall=0; front_stall=0, idex_bubble=0 that cycle (branch beats load-use).
REQ-024 SHALL suppress front_stall, idex_bubble and both flushes whenever pipe_stall=1; held branch_taken/lu re-evaluate on release cycle.
REQ-025 SHALL sample wb_halt only when pipe_stall=0; wb_halt=1 -> HALTED next cycle, halted=1 from that cycle.
REQ-026 SHALL leave HALTED only via reset; halted and err sticky.
REQ-027 SHALL generate all control outputs combinationally from current state and inputs (no added latency).

Reset
REQ-028 SHALL on rst=0 at a clk edge set state=RUN, counter=0, halted=0, err=0, regardless of current state (incl. mid MEM_WAIT).
REQ-029 SHALL force front_stall, idex_bubble, ifid_flush, idex_flush, pipe_stall to 0 while rst=0.

Verification
REQ-030 Load-use: ex_memRead=1, ex_regWrite=1, ex_rd=3, id_rs=3, id_rs_used=1 -> front_stall=1, idex_bubble=1 exactly one cycle, state stays 00.
REQ-031 Mem wait: dmem_req=1, dmem_done=0 for 3 cycles then 1 -> pipe_stall=1 for 3 cycles, 0 on done cycle, state 00->01->01->01->00.
REQ-032 Timeout: dmem_req=1, dmem_done held 0 -> state=10, err=1, halted=0 after 16 stalled cycles; stays until rst=0.
REQ-033 Branch+load-use same cycle: branch_taken=1 with lu conditions -> ifid_flush=idex_flush=1, front_stall=idex_bubble=0.
REQ-034 Branch during mem wait: branch_taken=1 through 2-cycle wait -> no flush while stalled, flushes=1 on release cycle.
REQ-035 Halt then reset: wb_halt=1 (pipe_stall=0) -> next cycle halted=1, state=10, pipe_stall=1; rst=0 one edge -> state=00, all outputs 0.
